// File: rtl/pll_reconfig_pkg.sv
// Shared constants and state encoding for the PLL reconfiguration master.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_K     = 6'd7;

  // Mode word 0 selects waitrequest mode; writing 1 to START kicks the reconfig.
  localparam logic [31:0] MODE_WAITREQ = 32'h0000_0000;
  localparam logic [31:0] START_GO     = 32'h0000_0001;

  localparam logic [31:0] M_VAL_DEF  = 32'h0000_0404;
  localparam logic [31:0] K_PAL_DEF  = 32'h8331_E3A8;
  localparam logic [31:0] K_NTSC_DEF = 32'h9745_BF27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MODE,
    S_W_M,
    S_W_K,
    S_W_START,
    S_WAIT_LOCK
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Avalon-MM master retuning the video PLL fractional divider between PAL and NTSC.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter logic [31:0] M_VAL       = M_VAL_DEF,
  parameter logic [31:0] K_PAL       = K_PAL_DEF,
  parameter logic [31:0] K_NTSC      = K_NTSC_DEF,
  parameter logic        INIT_PAL    = 1'b1,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned TIMEOUT     = 32'd1 << 20
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pal_req,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        applied_pal,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);

  logic pal_s;
  logic lock_s;

  sync2 #(.RST_VAL(INIT_PAL)) u_sync_pal (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pal_req),
    .q_o   (pal_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_lock (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  state_e        state_q, state_d;
  logic          target_q, target_d;
  logic          applied_q, applied_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stab_q, stab_d;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= INIT_PAL;
      applied_q <= INIT_PAL;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      tmo_q     <= '0;
      stab_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      done_q    <= done_d;
      error_q   <= error_d;
      tmo_q     <= tmo_d;
      stab_q    <= stab_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    applied_d      = applied_q;
    done_d         = 1'b0;
    error_d        = error_q;
    tmo_d          = tmo_q;
    stab_d         = stab_q;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;

    if (state_q != S_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pal_s != applied_q) begin
          target_d = pal_s;
          tmo_d    = '0;
          state_d  = S_W_MODE;
        end
      end
      S_W_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_MODE;
        mgmt_writedata = MODE_WAITREQ;
        if (!mgmt_waitrequest) state_d = S_W_M;
      end
      S_W_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_M;
        mgmt_writedata = M_VAL;
        if (!mgmt_waitrequest) state_d = S_W_K;
      end
      S_W_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_K;
        mgmt_writedata = target_q ? K_PAL : K_NTSC;
        if (!mgmt_waitrequest) state_d = S_W_START;
      end
      S_W_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_START;
        mgmt_writedata = START_GO;
        if (!mgmt_waitrequest) begin
          stab_d  = '0;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          applied_d = target_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else; the strobe is withheld in the final
    // cycle so the core can never accept a write on the abort edge.
    if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      mgmt_write = 1'b0;
      error_d    = 1'b1;
      done_d     = 1'b0;
      applied_d  = applied_q;
      state_d    = S_IDLE;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign applied_pal = applied_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
